// File: rtl/axi4_stream_pkt_src_if.sv
// AXI4-Stream link between the packet source and its drain.
// Master drives TDATA/TKEEP/TLAST/TVALID, slave returns TREADY.
interface axi4_stream_pkt_src_if #(
    parameter int unsigned DN = 4,
    parameter int unsigned DW = 8
) ();
    logic [DN*DW-1:0] TDATA;
    logic [DN-1:0]    TKEEP;
    logic             TLAST;
    logic             TVALID;
    logic             TREADY;

    modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axi4_stream_pkt_src.sv
// AXI4-Stream ramp-pattern packet source.
// Packets carry samples init + n*step (mod 2^DW), DN lanes per beat, TKEEP
// marks the valid lanes of the final beat and TLAST closes each packet.
// Optional inter-packet gap in repeat mode: define AXI4_STREAM_PKT_SRC_GAP_EN
// (adds cfg_gap input and the GAP state).
module axi4_stream_pkt_src #(
    parameter int unsigned DN = 4,
    parameter int unsigned DW = 8,
    parameter int unsigned LW = 16
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    input  logic [LW-1:0] cfg_len,
    input  logic [DW-1:0] cfg_init,
    input  logic [DW-1:0] cfg_step,
    input  logic          cfg_rpt,
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
    input  logic [15:0]   cfg_gap,
`endif
    input  logic          ctl_start,
    input  logic          ctl_stop,
    output logic          sts_busy,
    output logic [31:0]   sts_pkt,
    axi4_stream_pkt_src_if.master m_axis
);

    localparam logic [LW-1:0] DN_L = LW'(DN);
    localparam logic [DW-1:0] DN_W = DW'(DN);

`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

    state_t           r_state;
    logic [DN*DW-1:0] r_tdata;
    logic [DN-1:0]    r_tkeep;
    logic             r_tlast;
    logic             r_tvalid;
    logic             r_busy;
    logic [31:0]      r_pkt;
    logic [DW-1:0]    r_step;
    logic             r_rpt;
    logic             r_stop;
    logic [DW-1:0]    r_nbase;   // first sample value of the next beat
    logic [LW-1:0]    r_nrem;    // samples remaining after the presented beat
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
    logic [15:0]      r_gap;
    logic [15:0]      r_gcnt;
`endif

    logic             w_xfer;
    logic             w_stop_any;
    logic             w_start;
    logic             w_adv;
    logic             w_gap;
    logic             w_idle;
    logic [DW-1:0]    w_src_base;
    logic [DW-1:0]    w_src_step;
    logic [LW-1:0]    w_src_rem;
    logic [DN*DW-1:0] w_data;
    logic [DN-1:0]    w_keep;
    logic             w_last;
    logic [DW-1:0]    w_nbase;
    logic [LW-1:0]    w_nrem;

    // Lane data of one beat; lanes past the remaining sample count read 0.
    function automatic logic [DN*DW-1:0] f_data(input logic [DW-1:0] base,
                                                 input logic [DW-1:0] step,
                                                 input logic [LW-1:0] rem);
        logic [DN*DW-1:0] d;
        logic [DW-1:0]    v;
        d = '0;
        v = base;
        for (int unsigned i = 0; i < DN; i++) begin
            if (LW'(i) < rem) d[i*DW +: DW] = v;
            v = v + step;
        end
        return d;
    endfunction

    // Lane keep mask: one bit per lane still holding a sample.
    function automatic logic [DN-1:0] f_keep(input logic [LW-1:0] rem);
        logic [DN-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < DN; i++) k[i] = (LW'(i) < rem);
        return k;
    endfunction

    assign w_xfer     = r_tvalid & m_axis.TREADY;
    assign w_stop_any = r_stop | ctl_stop;

    // Next-step decision: start a packet, advance a beat, enter gap or go idle.
    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_gap   = 1'b0;
        w_idle  = 1'b0;
        case (r_state)
            S_IDLE: w_start = ctl_start && (cfg_len != '0);
            S_RUN: begin
                if (w_xfer) begin
                    if (!r_tlast) begin
                        w_adv = 1'b1;
                    end else if (r_rpt && !w_stop_any) begin
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
                        if (r_gap != '0)             w_gap   = 1'b1;
                        else if (cfg_len != '0)      w_start = 1'b1;
                        else                         w_idle  = 1'b1;
`else
                        if (cfg_len != '0)           w_start = 1'b1;
                        else                         w_idle  = 1'b1;
`endif
                    end else begin
                        w_idle = 1'b1;
                    end
                end
            end
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
            S_GAP: begin
                if (r_gcnt <= 16'd1) begin
                    if (w_stop_any || cfg_len == '0) w_idle  = 1'b1;
                    else                             w_start = 1'b1;
                end
            end
`endif
            default: w_idle = 1'b1;
        endcase
    end

    // Beat source: fresh configuration on packet start, otherwise the stored next beat.
    always_comb begin
        w_src_base = w_start ? cfg_init : r_nbase;
        w_src_step = w_start ? cfg_step : r_step;
        w_src_rem  = w_start ? cfg_len  : r_nrem;
        w_data     = f_data(w_src_base, w_src_step, w_src_rem);
        w_keep     = f_keep(w_src_rem);
        w_last     = (w_src_rem <= DN_L);
        w_nbase    = w_src_base + DN_W * w_src_step;
        w_nrem     = (w_src_rem > DN_L) ? (w_src_rem - DN_L) : '0;
    end

    // Control state, latched configuration and registered stream outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= S_IDLE;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_pkt    <= '0;
            r_step   <= '0;
            r_rpt    <= 1'b0;
            r_stop   <= 1'b0;
            r_nbase  <= '0;
            r_nrem   <= '0;
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
            r_gap    <= '0;
            r_gcnt   <= '0;
`endif
        end else begin
            if (w_xfer && r_tlast) r_pkt <= r_pkt + 32'd1;
            if (r_state != S_IDLE && ctl_stop) r_stop <= 1'b1;
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
            if (r_state == S_GAP) r_gcnt <= r_gcnt - 16'd1;
`endif
            if (w_start) begin
                r_state  <= S_RUN;
                r_busy   <= 1'b1;
                r_tvalid <= 1'b1;
                r_tdata  <= w_data;
                r_tkeep  <= w_keep;
                r_tlast  <= w_last;
                r_nbase  <= w_nbase;
                r_nrem   <= w_nrem;
                r_step   <= cfg_step;
                r_rpt    <= cfg_rpt;
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
                r_gap    <= cfg_gap;
`endif
                // start together with stop: send exactly this one packet
                if (r_state == S_IDLE) r_stop <= ctl_stop;
            end else if (w_adv) begin
                r_tdata  <= w_data;
                r_tkeep  <= w_keep;
                r_tlast  <= w_last;
                r_nbase  <= w_nbase;
                r_nrem   <= w_nrem;
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
            end else if (w_gap) begin
                r_state  <= S_GAP;
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
                r_gcnt   <= r_gap;
`endif
            end else if (w_idle) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tkeep  <= '0;
                r_tlast  <= 1'b0;
                r_stop   <= 1'b0;
            end
        end
    end

    assign m_axis.TDATA  = r_tdata;
    assign m_axis.TKEEP  = r_tkeep;
    assign m_axis.TLAST  = r_tlast;
    assign m_axis.TVALID = r_tvalid;
    assign sts_busy      = r_busy;
    assign sts_pkt       = r_pkt;

endmodule

// File: tb/tb_axi4_stream_pkt_src.sv
// Scoreboard bench for axi4_stream_pkt_src (DN=4, DW=8, LW=16).
// Expected beats are queued when a packet is requested and compared as the
// DUT transfers them; backpressure stability is checked on every held beat.
module tb_axi4_stream_pkt_src;

    localparam int unsigned DN = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 16;

    typedef struct {
        logic [DN*DW-1:0] data;
        logic [DN-1:0]    keep;
        logic             last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [DW-1:0] cfg_init = '0;
    logic [DW-1:0] cfg_step = '0;
    logic          cfg_rpt = 1'b0;
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
    logic [15:0]   cfg_gap = '0;
`endif
    logic          ctl_start = 1'b0;
    logic          ctl_stop = 1'b0;
    logic          sts_busy;
    logic [31:0]   sts_pkt;

    axi4_stream_pkt_src_if #(.DN(DN), .DW(DW)) axis ();

    axi4_stream_pkt_src #(.DN(DN), .DW(DW), .LW(LW)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cfg_len   (cfg_len),
        .cfg_init  (cfg_init),
        .cfg_step  (cfg_step),
        .cfg_rpt   (cfg_rpt),
`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
        .cfg_gap   (cfg_gap),
`endif
        .ctl_start (ctl_start),
        .ctl_stop  (ctl_stop),
        .sts_busy  (sts_busy),
        .sts_pkt   (sts_pkt),
        .m_axis    (axis.master)
    );

    always #5 ACLK = ~ACLK;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_cyc = 0;
    int    n_beats = 0;
    bit    mon_en = 1'b0;
    bit    rdy_rand = 1'b0;
    bit    hold = 1'b0;
    bit    prev_busy = 1'b0;
    logic [DN*DW-1:0] h_data;
    logic [DN-1:0]    h_keep;
    logic             h_last;
    int unsigned exp_pkt = 0;
    beat_t q[$];

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference packet: sample n = init + n*step, beat k lane i = sample k*DN+i.
    task automatic push_pkt(input int unsigned len, input logic [DW-1:0] init, input logic [DW-1:0] step);
        int unsigned nb;
        beat_t b;
        logic [DW-1:0] s;
        nb = (len + DN - 1) / DN;
        for (int unsigned k = 0; k < nb; k++) begin
            b.data = '0;
            b.keep = '0;
            for (int unsigned i = 0; i < DN; i++) begin
                if (k*DN + i < len) begin
                    s = init + DW'((k*DN + i) * int'(step));
                    b.data[i*DW +: DW] = s;
                    b.keep[i] = 1'b1;
                end
            end
            b.last = (k == nb - 1);
            q.push_back(b);
        end
        exp_pkt++;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_pkt(input int unsigned len, input logic [DW-1:0] init,
                             input logic [DW-1:0] step, input logic rpt, input logic stop);
        tick();
        cfg_len   = LW'(len);
        cfg_init  = init;
        cfg_step  = step;
        cfg_rpt   = rpt;
        ctl_start = 1'b1;
        ctl_stop  = stop;
        tick();
        ctl_start = 1'b0;
        ctl_stop  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sts_busy && n < 300) begin
            tick();
            n++;
        end
        chk_eq("idle_reached", sts_busy, 0);
        chk_eq("queue_drained", q.size(), 0);
        chk_eq("pkt_count", sts_pkt, exp_pkt);
    endtask

    task automatic wait_pkt(input int unsigned target);
        int n;
        n = 0;
        while (sts_pkt != target && n < 100) begin
            tick();
            n++;
        end
        chk_eq("pkt_wait", sts_pkt, target);
    endtask

    always @(posedge ACLK) cyc++;

    always @(posedge ACLK) begin
        if (rdy_rand) begin
            #1;
            axis.TREADY = ($urandom_range(0, 99) < 30);
        end
    end

    // Monitor: hold stability, scoreboard pop on transfer, busy fall latency.
    always @(negedge ACLK) begin
        if (!mon_en) begin
            hold      = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (hold) begin
                chk_eq("hold_valid", axis.TVALID, 1);
                chk_eq("hold_data",  axis.TDATA, h_data);
                chk_eq("hold_keep",  axis.TKEEP, h_keep);
                chk_eq("hold_last",  axis.TLAST, h_last);
            end
            hold   = axis.TVALID && !axis.TREADY;
            h_data = axis.TDATA;
            h_keep = axis.TKEEP;
            h_last = axis.TLAST;
            if (axis.TVALID && axis.TREADY) begin
                beat_t e;
                n_beats++;
                chk_eq("beat_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk_eq("tdata", axis.TDATA, e.data);
                    chk_eq("tkeep", axis.TKEEP, e.keep);
                    chk_eq("tlast", axis.TLAST, e.last);
                end
                if (axis.TLAST) last_cyc = cyc;
            end
            if (prev_busy && !sts_busy) chk_eq("busy_fall_latency", cyc - last_cyc, 1);
            prev_busy = sts_busy;
        end
    end

    initial begin
        int n;
        int n0;
        axis.TREADY = 1'b1;
        repeat (3) tick();
        chk_eq("rst_tvalid", axis.TVALID, 0);
        chk_eq("rst_tdata",  axis.TDATA, 0);
        chk_eq("rst_tkeep",  axis.TKEEP, 0);
        chk_eq("rst_tlast",  axis.TLAST, 0);
        chk_eq("rst_busy",   sts_busy, 0);
        chk_eq("rst_pkt",    sts_pkt, 0);
        ARESETn = 1'b1;
        mon_en  = 1'b1;
        tick();

        // 1: two full beats, TVALID one cycle after start
        chk_eq("t1_valid_pre", axis.TVALID, 0);
        push_pkt(8, 8'h10, 8'h01);
        start_pkt(8, 8'h10, 8'h01, 1'b0, 1'b0);
        chk_eq("t1_valid_rise", axis.TVALID, 1);
        chk_eq("t1_busy_rise", sts_busy, 1);
        chk_eq("t1_beat0", axis.TDATA, 32'h13121110);
        wait_idle();

        // 2: partial last beat with 8-bit wrap
        push_pkt(6, 8'hFE, 8'h01);
        start_pkt(6, 8'hFE, 8'h01, 1'b0, 1'b0);
        wait_idle();

        // 3: random backpressure, start while running is ignored
        n0 = n_beats;
        push_pkt(16, DW'($urandom_range(0, 255)), 8'h00);
        q.delete();
        exp_pkt--;
        cfg_init = DW'($urandom_range(0, 255));
        cfg_step = DW'($urandom_range(1, 255));
        push_pkt(16, cfg_init, cfg_step);
        start_pkt(16, cfg_init, cfg_step, 1'b0, 1'b0);
        rdy_rand = 1'b1;
        cfg_len   = LW'(8);
        ctl_start = 1'b1;
        tick();
        ctl_start = 1'b0;
        wait_idle();
        chk_eq("t3_beats", n_beats - n0, 4);
        rdy_rand = 1'b0;
        tick();
        axis.TREADY = 1'b1;

        // 4: repeat, stop during the second packet
        push_pkt(3, 8'h30, 8'h05);
        push_pkt(3, 8'h30, 8'h05);
        start_pkt(3, 8'h30, 8'h05, 1'b1, 1'b0);
        wait_pkt(exp_pkt - 1);
        axis.TREADY = 1'b0;
        ctl_stop    = 1'b1;
        tick();
        ctl_stop    = 1'b0;
        axis.TREADY = 1'b1;
        wait_idle();
        repeat (4) tick();
        chk_eq("t4_no_third", axis.TVALID, 0);
        chk_eq("t4_pkt_final", sts_pkt, exp_pkt);

        // 5: zero length ignored; start+stop with repeat sends one packet
        start_pkt(0, 8'h00, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_eq("t5_len0_valid", axis.TVALID, 0);
            chk_eq("t5_len0_busy", sts_busy, 0);
            tick();
        end
        push_pkt(5, 8'h20, 8'h03);
        start_pkt(5, 8'h20, 8'h03, 1'b1, 1'b1);
        wait_idle();
        repeat (4) tick();
        chk_eq("t5_one_pkt_valid", axis.TVALID, 0);
        chk_eq("t5_one_pkt_count", sts_pkt, exp_pkt);

        // 6: reset during beat 2 of a 4-beat packet, then a fresh packet
        n0 = n_beats;
        push_pkt(16, 8'h40, 8'h02);
        start_pkt(16, 8'h40, 8'h02, 1'b0, 1'b0);
        n = 0;
        while (n_beats < n0 + 1 && n < 50) begin
            tick();
            n++;
        end
        chk_eq("t6_first_beat_seen", n_beats - n0, 1);
        mon_en  = 1'b0;
        ARESETn = 1'b0;
        #1;
        chk_eq("t6_rst_tvalid", axis.TVALID, 0);
        chk_eq("t6_rst_tdata",  axis.TDATA, 0);
        chk_eq("t6_rst_tkeep",  axis.TKEEP, 0);
        chk_eq("t6_rst_tlast",  axis.TLAST, 0);
        chk_eq("t6_rst_busy",   sts_busy, 0);
        chk_eq("t6_rst_pkt",    sts_pkt, 0);
        q.delete();
        exp_pkt = 0;
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
        mon_en = 1'b1;
        push_pkt(16, 8'h40, 8'h02);
        start_pkt(16, 8'h40, 8'h02, 1'b0, 1'b0);
        chk_eq("t6_fresh_beat0", axis.TDATA, 32'h46444240);
        wait_idle();

`ifdef AXI4_STREAM_PKT_SRC_GAP_EN
        // gap of 3 idle cycles between repeated packets
        cfg_gap = 16'd3;
        push_pkt(4, 8'h50, 8'h01);
        push_pkt(4, 8'h50, 8'h01);
        start_pkt(4, 8'h50, 8'h01, 1'b1, 1'b0);
        wait_pkt(exp_pkt - 1);
        n = 0;
        while (!axis.TVALID && n < 20) begin
            n++;
            tick();
        end
        chk_eq("gap_cycles", n, 3);
        ctl_stop = 1'b1;
        tick();
        ctl_stop = 1'b0;
        wait_idle();
        cfg_gap = 16'd0;
`endif

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
